// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART byte-to-word packer.
// The CHK state exists only when UART_RX_CHECKSUM_EN is defined.
package uart_pkg;

`ifdef UART_RX_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_CHK  = 2'd3
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } rx_state_e;
`endif

  localparam logic [7:0] DEFAULT_HEADER         = 8'hA5;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/rx_gap_timer.sv
// Saturating inter-byte gap counter; expired pulses in the cycle the
// count would reach TIMEOUT_CYCLES with no clear present.
module rx_gap_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte event in the limit cycle wins over the timeout.
  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_packer.sv
// Packs HEADER,hi,lo[,chk] UART byte frames into 16-bit words with a
// valid/ready output. Define UART_RX_CHECKSUM_EN to require the XOR checksum byte.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_frame_err,
  output logic        o_overrun
);

  rx_state_e   state_q, state_d;
  logic        rx_done_q;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        byte_ev;
  logic        gap_expired;
  logic        complete;
  logic        chk_err;
  logic [15:0] new_word;

  assign byte_ev = i_rx_done && !rx_done_q;

  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (byte_ev || (state_q == ST_IDLE)),
    .enable (state_q != ST_IDLE),
    .expired(gap_expired)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    complete = 1'b0;
    chk_err  = 1'b0;
    new_word = {hi_q, i_rx_data};
    case (state_q)
      ST_IDLE: begin
        if (byte_ev && (i_rx_data == HEADER)) state_d = ST_HI;
      end
      ST_HI: begin
        // HEADER value here is payload, never a resync.
        if (byte_ev) begin
          hi_d    = i_rx_data;
          state_d = ST_LO;
        end else if (gap_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (byte_ev) begin
          lo_d = i_rx_data;
`ifdef UART_RX_CHECKSUM_EN
          state_d = ST_CHK;
`else
          complete = 1'b1;
          state_d  = ST_IDLE;
`endif
        end else if (gap_expired) begin
          state_d = ST_IDLE;
        end
      end
`ifdef UART_RX_CHECKSUM_EN
      ST_CHK: begin
        if (byte_ev) begin
          state_d = ST_IDLE;
          if (i_rx_data == (hi_q ^ lo_q)) begin
            complete = 1'b1;
            new_word = {hi_q, lo_q};
          end else begin
            chk_err = 1'b1;
          end
        end else if (gap_expired) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = gap_expired || chk_err;
    if (complete) begin
      // A held, unaccepted word is never overwritten.
      if (valid_q && !i_word_ready) begin
        overrun_d = 1'b1;
      end else begin
        word_d  = new_word;
        valid_d = 1'b1;
      end
    end else if (valid_q && i_word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rx_done_q   <= 1'b0;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      word_q      <= 16'h0000;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_done_q   <= i_rx_done;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;

endmodule
